snake_step_gen: RTL and testbench

SNAKE_STEP_GEN -- requirements
Module: snake_step_gen

---
 rtl/snake_step_gen.sv | 105 ++++++++++
 tb/tb_snake_step_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_step_gen.sv
// rtl/snake_step_gen.sv - snake path position generator with prescaled auto-stepping and jog
// Two-state STOP/RUN controller; step walks 0..STEPS-1 in either direction with wrap pulses.
module snake_step_gen #(
    parameter int DIV   = 25000000,
    parameter int STEPS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       jog,
    output logic [4:0] step,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [4:0]    STEP_LAST = 5'(STEPS - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      step_q, step_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            adv;

    // Stop wins over a terminal count; jog only acts when staying in STOP.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        adv     = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (jog) begin
                    adv = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_STOP;
                end else if (cnt_q == CNT_LAST) begin
                    adv = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Explicit end-of-path compares keep step inside 0..STEPS-1.
    always_comb begin
        step_d = step_q;
        tick_d = adv;
        wrap_d = 1'b0;
        if (adv) begin
            if (dir) begin
                if (step_q == 5'd0) begin
                    step_d = STEP_LAST;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step_q - 5'd1;
                end
            end else begin
                if (step_q == STEP_LAST) begin
                    step_d = 5'd0;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            step_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign step    = step_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_snake_step_gen.sv
// tb/tb_snake_step_gen.sv - directed and randomized bench for snake_step_gen
// Reference model tracks run age and step with plain modular arithmetic.
module tb_snake_step_gen;

    localparam int DIV   = 4;
    localparam int STEPS = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       dir;
    logic       jog;
    logic [4:0] step;
    logic       tick;
    logic       wrap;
    logic       running;

    int checks = 0;
    int errors = 0;
    int tick_total;
    int wrap_total;

    bit m_run;
    int m_age;
    int m_step;
    bit m_tick;
    bit m_wrap;

    snake_step_gen #(.DIV(DIV), .STEPS(STEPS)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .dir     (dir),
        .jog     (jog),
        .step    (step),
        .tick    (tick),
        .wrap    (wrap),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_age  = 0;
        m_step = 0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
    endtask

    // One rising edge: advance when the run age hits a multiple of DIV, or on a jog while idle.
    task automatic model_edge();
        bit adv;
        adv    = 1'b0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (!m_run) begin
            if (run) begin
                m_run = 1'b1;
                m_age = 0;
            end else if (jog) begin
                adv = 1'b1;
            end
        end else if (!run) begin
            m_run = 1'b0;
        end else begin
            m_age++;
            if (m_age % DIV == 0) adv = 1'b1;
        end
        if (adv) begin
            m_tick = 1'b1;
            if (dir) begin
                m_wrap = (m_step == 0);
                m_step = (m_step + STEPS - 1) % STEPS;
            end else begin
                m_wrap = (m_step == STEPS - 1);
                m_step = (m_step + 1) % STEPS;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_step"}, 32'(step), m_step);
        chk({tag, "_tick"}, 32'(tick), int'(m_tick));
        chk({tag, "_wrap"}, 32'(wrap), int'(m_wrap));
        chk({tag, "_running"}, 32'(running), int'(m_run));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
        tick_total += int'(tick);
        wrap_total += int'(wrap);
    endtask

    // Called 1 time unit after an edge; the pulse sits entirely between edges.
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        dir = 1'b0;
        jog = 1'b0;
        tick_total = 0;
        wrap_total = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_hold");
        rst = 1'b0;

        // Continuous forward run for 85 edges
        run = 1'b1;
        dir = 1'b0;
        tick_total = 0;
        wrap_total = 0;
        repeat (85) cycle();
        chk("fwd_tick_total", 32'(tick_total), 21);
        chk("fwd_wrap_total", 32'(wrap_total), 1);
        chk("fwd_final_step", 32'(step), 1);
        run = 1'b0;
        cycle();
        rst_pulse();

        // Reverse jog from 0 wraps to STEPS-1
        dir = 1'b1;
        jog = 1'b1;
        cycle();
        chk("jog_rev_step", 32'(step), STEPS - 1);
        chk("jog_rev_tick", 32'(tick), 1);
        chk("jog_rev_wrap", 32'(wrap), 1);
        chk("jog_rev_running", 32'(running), 0);
        jog = 1'b0;
        cycle();
        chk("jog_rev_tick_clear", 32'(tick), 0);

        // Short run burst: no advance
        dir = 1'b0;
        run = 1'b1;
        repeat (3) cycle();
        run = 1'b0;
        cycle();
        chk("burst_step", 32'(step), STEPS - 1);
        chk("burst_running", 32'(running), 0);
        cycle();

        // run and jog together: enter RUN without advance, first tick 4 cycles later
        run = 1'b1;
        jog = 1'b1;
        cycle();
        chk("runjog_running", 32'(running), 1);
        chk("runjog_tick", 32'(tick), 0);
        chk("runjog_step", 32'(step), STEPS - 1);
        jog = 1'b0;
        repeat (3) cycle();
        chk("runjog_pre_tick", 32'(tick), 0);
        cycle();
        chk("runjog_first_tick", 32'(tick), 1);
        chk("runjog_first_step", 32'(step), 0);
        chk("runjog_first_wrap", 32'(wrap), 1);

        // Async reset mid-count at step 7
        repeat (30) cycle();
        chk("pre_rst_step", 32'(step), 7);
        rst_pulse();
        chk("post_rst_step", 32'(step), 0);
        chk("post_rst_running", 32'(running), 0);
        cycle();
        repeat (3) cycle();
        chk("post_rst_no_tick", 32'(tick), 0);
        cycle();
        chk("post_rst_first_step", 32'(step), 1);
        chk("post_rst_first_tick", 32'(tick), 1);

        // Direction change between advances
        repeat (17) cycle();
        chk("dirchg_start_step", 32'(step), 5);
        dir = 1'b1;
        repeat (2) cycle();
        chk("dirchg_hold_step", 32'(step), 5);
        chk("dirchg_hold_tick", 32'(tick), 0);
        cycle();
        chk("dirchg_adv_step", 32'(step), 4);
        chk("dirchg_adv_tick", 32'(tick), 1);

        // Randomized mix with occasional asynchronous resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            jog = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 79) == 0) rst_pulse();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
